// File: rtl/data_mem_sync.sv
// Clocked data memory for the Core101 LSU: DEPTH x XLEN array, valid/ready handshake with
// WAIT_STATES wait cycles, sized loads/stores. Define DATA_MEM_MISALIGN_TRAP_EN to fault on misalignment.
module data_mem_sync #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic            clock_in,
  input  logic            reset_n_in,
  input  logic            data_mem_valid_in,
  input  logic            data_mem_write_in,
  input  logic [2:0]      data_mem_size_in,
  input  logic [XLEN-1:0] data_mem_addr_in,
  input  logic [XLEN-1:0] data_mem_data_in,
  output logic            data_mem_ready_out,
  output logic [XLEN-1:0] data_mem_data_out,
  output logic            data_mem_error_out,
  output logic [1:0]      dbg_state_out
);

  // Handshake: a request is accepted on a rising edge in IDLE with valid_in=1; the response is
  // the single cycle with ready_out=1, and data_out/error_out are meaningful only in that cycle.
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [2:0]        r_size;
  logic [IDX_W-1:0]  r_idx;
  logic [OFF_W-1:0]  r_off;
  logic [XLEN-1:0]   r_wdata;
  logic              r_fault;
  logic [XLEN-1:0]   r_mem [DEPTH];

  logic [OFF_W-1:0]  w_in_off;
  logic [OFF_W-1:0]  w_align_mask;
  logic [OFF_W-1:0]  w_off;
  logic              w_range_err;
  logic              w_size_err;
  logic              w_misalign;
  logic              w_fault;
  logic [NB-1:0]     w_base_strb;
  logic [NB-1:0]     w_strb;
  logic [XLEN-1:0]   w_wdata_sh;
  logic [XLEN-1:0]   w_rd_sh;
  logic [XLEN-1:0]   w_load;
  logic              w_ready;

  assign w_in_off    = data_mem_addr_in[OFF_W-1:0];
  assign w_range_err = (data_mem_addr_in >> (IDX_W + OFF_W)) != '0;
  assign w_size_err  = (data_mem_size_in == 3'b111) ||
                       ((XLEN == 32) && ((data_mem_size_in[1:0] == 2'b11) || (data_mem_size_in == 3'b110))) ||
                       (data_mem_write_in && data_mem_size_in[2]);

  always_comb begin
    w_align_mask = '0;
    case (data_mem_size_in[1:0])
      2'd0:    w_align_mask = '0;
      2'd1:    w_align_mask = OFF_W'(1);
      2'd2:    w_align_mask = OFF_W'(3);
      default: w_align_mask = OFF_W'(7);
    endcase
  end

  assign w_misalign = (w_in_off & w_align_mask) != '0;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign w_fault = w_range_err || w_size_err || w_misalign;
  assign w_off   = w_in_off;
`else
  // Misaligned accesses silently round down to the natural boundary.
  assign w_fault = w_range_err || w_size_err;
  assign w_off   = w_in_off & ~w_align_mask;
`endif

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_idx   <= '0;
      r_off   <= '0;
      r_wdata <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_mem_valid_in) begin
            r_write <= data_mem_write_in;
            r_size  <= data_mem_size_in;
            r_idx   <= data_mem_addr_in[IDX_W+OFF_W-1:OFF_W];
            r_off   <= w_off;
            r_wdata <= data_mem_data_in;
            r_fault <= w_fault;
            r_cnt   <= '0;
            r_state <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'(WAIT_STATES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_base_strb = '0;
    case (r_size[1:0])
      2'd0:    w_base_strb = NB'(1);
      2'd1:    w_base_strb = NB'(3);
      2'd2:    w_base_strb = NB'(15);
      default: w_base_strb = NB'(8'hFF);
    endcase
  end

  assign w_strb     = w_base_strb << r_off;
  assign w_wdata_sh = r_wdata << {r_off, 3'b000};

  // Store commits on the edge that leaves RESP; reset forces IDLE, so an abandoned store never lands.
  always_ff @(posedge clock_in) begin
    if (r_state == S_RESP && r_write && !r_fault) begin
      for (int b = 0; b < NB; b++) begin
        if (w_strb[b]) r_mem[r_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  assign w_rd_sh = r_mem[r_idx] >> {r_off, 3'b000};

  always_comb begin
    w_load = w_rd_sh;
    case (r_size)
      3'b000:  w_load = XLEN'($signed(w_rd_sh[7:0]));
      3'b001:  w_load = XLEN'($signed(w_rd_sh[15:0]));
      3'b010:  w_load = XLEN'($signed(w_rd_sh[31:0]));
      3'b100:  w_load = XLEN'(w_rd_sh[7:0]);
      3'b101:  w_load = XLEN'(w_rd_sh[15:0]);
      3'b110:  w_load = XLEN'(w_rd_sh[31:0]);
      default: w_load = w_rd_sh;
    endcase
  end

  assign w_ready            = (r_state == S_RESP);
  assign data_mem_ready_out = w_ready;
  assign data_mem_data_out  = (w_ready && !r_fault && !r_write) ? w_load : '0;
  assign data_mem_error_out = w_ready && r_fault;
  assign dbg_state_out      = r_state;

endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync: byte-array reference model, expected-response queue and a
// negedge monitor that checks data, error and response latency.
module tb_data_mem_sync;

  localparam int XLEN      = 32;
  localparam int DEPTH     = 64;
  localparam int WS        = 3;
  localparam int MEM_BYTES = DEPTH * (XLEN / 8);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid = 1'b0;
  logic            write = 1'b0;
  logic [2:0]      size = '0;
  logic [XLEN-1:0] addr = '0;
  logic [XLEN-1:0] wdata = '0;
  logic            ready;
  logic [XLEN-1:0] rdata;
  logic            err;
  logic [1:0]      dbg_state;

  data_mem_sync #(.XLEN(XLEN), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clock_in           (clk),
    .reset_n_in         (rst_n),
    .data_mem_valid_in  (valid),
    .data_mem_write_in  (write),
    .data_mem_size_in   (size),
    .data_mem_addr_in   (addr),
    .data_mem_data_in   (wdata),
    .data_mem_ready_out (ready),
    .data_mem_data_out  (rdata),
    .data_mem_error_out (err),
    .dbg_state_out      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [XLEN-1:0] exp_q[$];
  logic            exp_err_q[$];
  int              exp_cyc_q[$];
  logic [7:0]      model_mem [MEM_BYTES];
  int              checks = 0;
  int              errors = 0;

  // Reference model: the memory is a flat byte array addressed by the byte address.
  task automatic model_access(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] rd, output logic er);
    int          n;
    int          base;
    logic [63:0] v;
    n  = 1 << sz[1:0];
    er = 1'b0;
    rd = '0;
    if (a >= 32'(MEM_BYTES)) er = 1'b1;
    if (sz == 3'd7 || sz == 3'd3 || sz == 3'd6) er = 1'b1;
    if (wr && sz[2]) er = 1'b1;
    if (er) return;
    base = int'(a);
    if (base % n != 0) begin
`ifdef DATA_MEM_MISALIGN_TRAP_EN
      er = 1'b1;
      return;
`else
      base = base - (base % n);
`endif
    end
    if (wr) begin
      for (int i = 0; i < n; i++) model_mem[base + i] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (64'(model_mem[base + i]) << (8 * i));
      if (!sz[2] && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      rd = v[31:0];
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic use_exp, input logic [31:0] exp_d,
                        input logic exp_e);
    logic [31:0] m_d;
    logic        m_e;
    logic        done;
    @(negedge clk);
    valid = 1'b1; write = wr; size = sz; addr = a; wdata = d;
    model_access(wr, sz, a, d, m_d, m_e);
    exp_q.push_back(use_exp ? exp_d : m_d);
    exp_err_q.push_back(use_exp ? exp_e : m_e);
    // The edge after this negedge accepts; the monitor should see ready WS cycles later.
    exp_cyc_q.push_back(cyc + 1 + WS);
    done = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (ready) begin
        valid = 1'b0;
        done  = 1'b1;
        break;
      end
      valid = 1'($urandom_range(0, 1));
      write = 1'($urandom_range(0, 1));
      size  = 3'($urandom_range(0, 7));
      addr  = $urandom;
      wdata = $urandom;
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: ready not seen within 40 cycles (addr=%h)", a);
      valid = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: ready=1 with no request outstanding at cycle %0d", cyc);
        end else begin
          logic [XLEN-1:0] e_d;
          logic            e_e;
          int              e_c;
          e_d = exp_q.pop_front();
          e_e = exp_err_q.pop_front();
          e_c = exp_cyc_q.pop_front();
          if (rdata !== e_d || err !== e_e || cyc != e_c) begin
            errors++;
            $display("FAIL response: data=%h err=%b cycle=%0d, expected data=%h err=%b cycle=%0d",
                     rdata, err, cyc, e_d, e_e, e_c);
          end
        end
      end else begin
        checks++;
        if (rdata !== '0 || err !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: data=%h err=%b, expected 0 while ready=0", rdata, err);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (ready !== 1'b0 || rdata !== '0 || err !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL %s: ready=%b data=%h err=%b state=%0d, expected 0/0/0/0",
               tag, ready, rdata, err, dbg_state);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Give every word a known value so loads are predictable.
    for (int w = 0; w < DEPTH; w++) do_req(1'b1, 3'b010, 32'(w * 4), $urandom, 1'b0, '0, 1'b0);

    // Word store/load, then byte store and extended loads.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    do_req(1'b1, 3'b000, 32'h13, 32'h80, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 32'h00000080, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 32'hFFFF80AD, 1'b0);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, 1'b1, 32'h000080AD, 1'b0);

    // Out of range and illegal sizes, then the edge words.
    do_req(1'b0, 3'b010, 32'(MEM_BYTES), 32'h0, 1'b1, 32'h0, 1'b1);
    do_req(1'b1, 3'b010, 32'(MEM_BYTES), 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);
    do_req(1'b1, 3'b010, 32'hFFFF_FFFC, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, '0, 1'b0);
    do_req(1'b0, 3'b010, 32'(MEM_BYTES - 4), 32'h0, 1'b0, '0, 1'b0);
    do_req(1'b0, 3'b011, 32'h8, 32'h0, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 3'b110, 32'h8, 32'h0, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 3'b111, 32'h8, 32'h0, 1'b1, 32'h0, 1'b1);
    do_req(1'b1, 3'b100, 32'h8, 32'h55, 1'b1, 32'h0, 1'b1);

    // Misaligned word store: traps or rounds down depending on the build.
    do_req(1'b1, 3'b010, 32'h12, 32'h13572468, 1'b0, '0, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, '0, 1'b0);

    // Reset during the wait of a store abandons it.
    @(negedge clk);
    valid = 1'b1; write = 1'b1; size = 3'b010; addr = 32'h20; wdata = 32'h12345678;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_wait");
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, '0, 1'b0);

    // Randomised traffic, mostly in range.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      if ($urandom_range(0, 9) == 0) ra = 32'($urandom_range(MEM_BYTES, MEM_BYTES + 64));
      else                           ra = 32'($urandom_range(0, MEM_BYTES - 1));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, 1'b0, '0, 1'b0);
    end

    repeat (WS + 4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d responses never arrived, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
